// File: rtl/flash_user_pkg.sv
// Shared definitions for the flash traffic generator: bus widths, op-type codes,
// FSM state encoding and the data-pattern helpers used by both the writer and
// the checker.
// Optional build macro: FLASH_GEN_PRBS_EN selects an 8-bit LFSR pattern
// (x^8+x^6+x^5+x^4+1) instead of the default incrementing byte pattern.
package flash_user_pkg;

    localparam int ADDR_W = 24;
    localparam int NUM_W  = 9;

    localparam logic [1:0] OP_ERASE = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ER_REQ,
        ST_ER_WAIT,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_CHK,
        ST_DONE
    } gen_state_e;

    // Value of pattern byte 0 for iteration n.
    function automatic logic [7:0] pat_seed(input logic [7:0] seed, input logic [7:0] n);
`ifdef FLASH_GEN_PRBS_EN
        return (seed | 8'h01) ^ n;
`else
        return seed + n;
`endif
    endfunction

    // Advance the pattern by one byte.
    function automatic logic [7:0] pat_step(input logic [7:0] v);
`ifdef FLASH_GEN_PRBS_EN
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
        return v + 8'd1;
`endif
    endfunction

endpackage

// File: rtl/flash_user_if.sv
// User-side bus of the SPI-flash controller: command channel (type/addr/num
// with valid/ready), write byte stream and read byte stream.
// master: traffic generator side; slave: flash controller side.
interface flash_user_if;
    import flash_user_pkg::*;

    logic [1:0]        op_type;
    logic [ADDR_W-1:0] op_addr;
    logic [NUM_W-1:0]  op_num;
    logic              op_valid;
    logic              op_ready;
    logic [7:0]        write_data;
    logic              write_sop;
    logic              write_eop;
    logic              write_valid;
    logic [7:0]        read_data;
    logic              read_sop;
    logic              read_eop;
    logic              read_valid;

    modport master (
        output op_type, op_addr, op_num, op_valid,
        output write_data, write_sop, write_eop, write_valid,
        input  op_ready, read_data, read_sop, read_eop, read_valid
    );

    modport slave (
        input  op_type, op_addr, op_num, op_valid,
        input  write_data, write_sop, write_eop, write_valid,
        output op_ready, read_data, read_sop, read_eop, read_valid
    );
endinterface

// File: rtl/flash_gen_pattern.sv
// Pattern byte source. i_load takes a new seed, i_step advances one byte;
// o_byte is the current pattern byte. Used once for the writer and once for
// the read checker so both walk the same sequence independently.
// Ports: i_clk, i_rst_n (async, active low), i_load, i_seed[7:0], i_step, o_byte[7:0].
module flash_gen_pattern
    import flash_user_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_seed,
    input  logic       i_step,
    output logic [7:0] o_byte
);
    logic [7:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (i_load)      val_d = i_seed;
        else if (i_step) val_d = pat_step(val_q);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) val_q <= 8'h00;
        else          val_q <= val_d;
    end

    assign o_byte = val_q;
endmodule

// File: rtl/flash_traffic_gen.sv
// SPI-flash traffic generator/checker. Each iteration issues ERASE, WRITE
// (P_LEN bytes) and READ (P_LEN bytes) at a stepped address and checks the
// read stream against the written pattern. P_ITER iterations per i_start.
// Ports: i_clk, i_rst_n (async, active low), i_start (pulse), o_busy, o_done
// (pulse), o_pass (held), o_err_cnt[15:0] (saturating), user (flash_user_if.master).
// Optional build macro: FLASH_GEN_PRBS_EN (LFSR pattern, see flash_user_pkg).
module flash_traffic_gen
    import flash_user_pkg::*;
#(
    parameter logic [ADDR_W-1:0] P_BASE_ADDR = 24'h000000,
    parameter logic [ADDR_W-1:0] P_ADDR_STEP = 24'h001000,
    parameter int                P_LEN       = 4,
    parameter int                P_ITER      = 4,
    parameter logic [7:0]        P_SEED      = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [15:0] o_err_cnt,
    flash_user_if.master user
);
    localparam logic [NUM_W-1:0] LEN_N     = NUM_W'(P_LEN);
    localparam logic [NUM_W-1:0] LAST_K    = NUM_W'(P_LEN - 1);
    localparam logic [15:0]      ITER_LAST = 16'(P_ITER - 1);

    gen_state_e        st_q, st_d;
    logic [15:0]       iter_q, iter_d;
    logic [NUM_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       err_q, err_d;
    logic              pass_q, pass_d;
    logic              rdy_q, rdy_d;
    logic [1:0]        op_type_q, op_type_d;
    logic [ADDR_W-1:0] op_addr_q, op_addr_d;
    logic [NUM_W-1:0]  op_num_q, op_num_d;
    logic              op_valid_q, op_valid_d;

    logic        hs, rdy_rise;
    logic        wr_load, wr_step, ck_load, ck_step;
    logic [7:0]  wr_byte, ck_byte, iter_seed;
    logic [2:0]  inc;
    logic [16:0] err_sum;

    assign hs        = op_valid_q & user.op_ready;
    // The controller signals op completion by returning to ready.
    assign rdy_rise  = user.op_ready & ~rdy_q;
    assign iter_seed = pat_seed(P_SEED, iter_q[7:0]);

    flash_gen_pattern u_wr_pat (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_load (wr_load),
        .i_seed (iter_seed),
        .i_step (wr_step),
        .o_byte (wr_byte)
    );

    flash_gen_pattern u_ck_pat (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_load (ck_load),
        .i_seed (iter_seed),
        .i_step (ck_step),
        .o_byte (ck_byte)
    );

    always_comb begin
        st_d       = st_q;
        iter_d     = iter_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        pass_d     = pass_q;
        rdy_d      = user.op_ready;
        op_type_d  = op_type_q;
        op_addr_d  = op_addr_q;
        op_num_d   = op_num_q;
        op_valid_d = op_valid_q;
        wr_load    = 1'b0;
        wr_step    = 1'b0;
        ck_load    = 1'b0;
        ck_step    = 1'b0;
        inc        = 3'd0;
        err_sum    = 17'd0;

        case (st_q)
            ST_IDLE: if (i_start) begin
                iter_d     = 16'd0;
                err_d      = 16'd0;
                op_type_d  = OP_ERASE;
                op_addr_d  = P_BASE_ADDR;
                op_num_d   = '0;
                op_valid_d = 1'b1;
                st_d       = ST_ER_REQ;
            end
            ST_ER_REQ: if (hs) begin
                op_valid_d = 1'b0;
                st_d       = ST_ER_WAIT;
            end
            ST_ER_WAIT: if (rdy_rise) begin
                op_type_d  = OP_WRITE;
                op_num_d   = LEN_N;
                op_valid_d = 1'b1;
                wr_load    = 1'b1;
                st_d       = ST_WR_REQ;
            end
            ST_WR_REQ: if (hs) begin
                op_valid_d = 1'b0;
                cnt_d      = '0;
                st_d       = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                wr_step = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_K) st_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: if (rdy_rise) begin
                op_type_d  = OP_READ;
                op_valid_d = 1'b1;
                ck_load    = 1'b1;
                st_d       = ST_RD_REQ;
            end
            ST_RD_REQ: if (hs) begin
                op_valid_d = 1'b0;
                cnt_d      = '0;
                st_d       = ST_RD_CHK;
            end
            ST_RD_CHK: begin
                // Up to four error sources can fire in one cycle; each counts.
                if (user.read_valid) begin
                    ck_step = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    inc = inc + {2'b0, user.read_data != ck_byte};
                    inc = inc + {2'b0, user.read_sop != (cnt_q == '0)};
                    inc = inc + {2'b0, user.read_eop != (cnt_q == LAST_K)};
                end
                if (rdy_rise) begin
                    inc = inc + {2'b0, cnt_d != LEN_N};
                    if (iter_q < ITER_LAST) begin
                        iter_d     = iter_q + 16'd1;
                        op_type_d  = OP_ERASE;
                        op_addr_d  = op_addr_q + P_ADDR_STEP;
                        op_num_d   = '0;
                        op_valid_d = 1'b1;
                        st_d       = ST_ER_REQ;
                    end else begin
                        st_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                pass_d = (err_q == 16'd0);
                st_d   = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase

        if (inc != 3'd0) begin
            err_sum = {1'b0, err_d} + {14'd0, inc};
            err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q       <= ST_IDLE;
            iter_q     <= 16'd0;
            cnt_q      <= '0;
            err_q      <= 16'd0;
            pass_q     <= 1'b0;
            rdy_q      <= 1'b1;
            op_type_q  <= OP_ERASE;
            op_addr_q  <= P_BASE_ADDR;
            op_num_q   <= '0;
            op_valid_q <= 1'b0;
        end else begin
            st_q       <= st_d;
            iter_q     <= iter_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            pass_q     <= pass_d;
            rdy_q      <= rdy_d;
            op_type_q  <= op_type_d;
            op_addr_q  <= op_addr_d;
            op_num_q   <= op_num_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign o_busy    = (st_q != ST_IDLE);
    assign o_done    = (st_q == ST_DONE);
    assign o_pass    = pass_q;
    assign o_err_cnt = err_q;

    assign user.op_type     = op_type_q;
    assign user.op_addr     = op_addr_q;
    assign user.op_num      = op_num_q;
    assign user.op_valid    = op_valid_q;
    assign user.write_valid = (st_q == ST_WR_DATA);
    assign user.write_data  = user.write_valid ? wr_byte : 8'h00;
    assign user.write_sop   = user.write_valid & (cnt_q == '0);
    assign user.write_eop   = user.write_valid & (cnt_q == LAST_K);
endmodule

// File: tb/tb_flash_traffic_gen.sv
// Bench for flash_traffic_gen. dut: P_LEN=4, P_ITER=3, step 0x1000, driven by
// a reactive controller model with a byte memory (loopback). dut1: P_LEN=1,
// P_ITER=1, driven step by step from the main sequence.
module tb_flash_traffic_gen;
    import flash_user_pkg::*;

    localparam int          LEN   = 4;
    localparam int          ITER  = 3;
    localparam logic [23:0] STEP  = 24'h001000;
    localparam logic [23:0] BASE1 = 24'h0ABC00;
    localparam logic [7:0]  SEED1 = 8'h5A;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start1 = 1'b0;
    logic busy, done, pass, busy1, done1, pass1;
    logic [15:0] err, err1;
    int n_chk = 0, n_pass = 0;

    flash_user_if bus ();
    flash_user_if bus1 ();

    always #5 clk = ~clk;

    flash_traffic_gen #(.P_BASE_ADDR(24'h000000), .P_ADDR_STEP(STEP), .P_LEN(LEN),
                        .P_ITER(ITER), .P_SEED(8'h00)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
        .o_pass(pass), .o_err_cnt(err), .user(bus.master));

    flash_traffic_gen #(.P_BASE_ADDR(BASE1), .P_ADDR_STEP(STEP), .P_LEN(1),
                        .P_ITER(1), .P_SEED(SEED1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
        .o_pass(pass1), .o_err_cnt(err1), .user(bus1.master));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] pat(input logic [7:0] seed, input int n, input int k);
        logic [7:0] v;
`ifdef FLASH_GEN_PRBS_EN
        v = (seed | 8'h01) ^ 8'(n);
        for (int i = 0; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
        v = seed + 8'(n) + 8'(k);
`endif
        return v;
    endfunction

    // ---------------- scoreboard + controller model for dut ----------------
    logic [34:0] exp_op_q[$];   // {type, addr, num}
    logic [9:0]  exp_wr_q[$];   // {data, sop, eop}
    logic [7:0]  mem [int];
    int hold = 2, stall = 0;
    logic corrupt_en = 1'b0;

    typedef enum {C_IDLE, C_HS, C_EXEC} cst_e;
    cst_e c_st = C_IDLE;
    int waitc = 0, cnt = 0, rd_idx = 0, wr_seen = 0;
    logic [34:0] held_op, cur_op, exp_op;
    logic [7:0] rd_d;

    task automatic push_run();
        logic [23:0] a;
        for (int n = 0; n < ITER; n++) begin
            a = 24'(n) * STEP;
            exp_op_q.push_back({OP_ERASE, a, 9'd0});
            exp_op_q.push_back({OP_WRITE, a, 9'(LEN)});
            exp_op_q.push_back({OP_READ,  a, 9'(LEN)});
            for (int k = 0; k < LEN; k++)
                exp_wr_q.push_back({pat(8'h00, n, k), k == 0, k == LEN - 1});
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            c_st = C_IDLE; waitc = 0;
            bus.op_ready = 1'b1; bus.read_valid = 1'b0; bus.read_data = 8'h00;
            bus.read_sop = 1'b0; bus.read_eop = 1'b0;
        end else begin
            if (bus.write_valid) begin
                chk("wr_pending", 64'(exp_wr_q.size() > 0), 64'd1);
                if (exp_wr_q.size() > 0)
                    chk("wr_byte", 64'({bus.write_data, bus.write_sop, bus.write_eop}),
                        64'(exp_wr_q.pop_front()));
                mem[int'(cur_op[32:9]) + wr_seen] = bus.write_data;
                wr_seen++;
            end
            case (c_st)
                C_IDLE: begin
                    if (waitc > 0)
                        chk("op_stable", 64'({bus.op_valid, bus.op_type, bus.op_addr, bus.op_num}),
                            64'({1'b1, held_op}));
                    if (bus.op_valid) begin
                        if (waitc == 0) held_op = {bus.op_type, bus.op_addr, bus.op_num};
                        if (waitc < stall) begin
                            bus.op_ready = 1'b0;
                            waitc++;
                        end else begin
                            // ready high now -> handshake on the next posedge
                            bus.op_ready = 1'b1;
                            cur_op = {bus.op_type, bus.op_addr, bus.op_num};
                            chk("op_pending", 64'(exp_op_q.size() > 0), 64'd1);
                            if (exp_op_q.size() > 0) begin
                                exp_op = exp_op_q.pop_front();
                                chk("op_fields", 64'(cur_op), 64'(exp_op));
                            end
                            waitc = 0; wr_seen = 0; rd_idx = 0;
                            c_st = C_HS;
                        end
                    end else begin
                        bus.op_ready = 1'b1;
                    end
                end
                C_HS: begin
                    chk("op_valid_drop", 64'(bus.op_valid), 64'd0);
                    bus.op_ready = 1'b0;
                    if (cur_op[34:33] == OP_ERASE)
                        for (int i = 0; i < 256; i++) mem.delete(int'(cur_op[32:9]) + i);
                    cnt = hold;
                    c_st = C_EXEC;
                end
                default: begin
                    bus.op_ready = 1'b0;
                    if (cur_op[34:33] == OP_READ && rd_idx < int'(cur_op[8:0])) begin
                        rd_d = mem.exists(int'(cur_op[32:9]) + rd_idx) ?
                               mem[int'(cur_op[32:9]) + rd_idx] : 8'hFF;
                        if (corrupt_en && cur_op[32:9] == 24'h0 && rd_idx == 2) rd_d = 8'hFF;
                        bus.read_valid = 1'b1;
                        bus.read_data  = rd_d;
                        bus.read_sop   = (rd_idx == 0);
                        bus.read_eop   = (rd_idx == int'(cur_op[8:0]) - 1);
                        rd_idx++;
                    end else begin
                        bus.read_valid = 1'b0; bus.read_sop = 1'b0; bus.read_eop = 1'b0;
                        if (cur_op[34:33] == OP_WRITE && wr_seen < int'(cur_op[8:0])) begin
                            cnt = cnt; // still collecting write bytes
                        end else if (cnt > 0) begin
                            cnt--;
                        end else begin
                            bus.op_ready = 1'b1;
                            c_st = C_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- helpers for the directed sequence ----------------
    task automatic pulse_start(input string tag);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk(tag, 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input string tag, input logic [15:0] exp_err, input logic exp_pass);
        int c = 0;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        @(negedge clk);
        chk({tag, "_pass"}, 64'({pass, busy, done}), 64'({exp_pass, 2'b00}));
        chk({tag, "_left"}, 64'(exp_op_q.size() + exp_wr_q.size()), 64'd0);
    endtask

    task automatic wait_valid1(input string tag, input logic [34:0] exp);
        int c = 0;
        while (!bus1.op_valid && c < 200) begin @(negedge clk); c++; end
        chk(tag, 64'({bus1.op_valid, bus1.op_type, bus1.op_addr, bus1.op_num}), 64'({1'b1, exp}));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        bus1.op_ready = 1'b1; bus1.read_valid = 1'b0; bus1.read_data = 8'h00;
        bus1.read_sop = 1'b0; bus1.read_eop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 64'({busy, done, pass, err}), 64'd0);
        chk("rst_op", 64'({bus.op_type, bus.op_addr, bus.op_num, bus.op_valid}), 64'd0);
        chk("rst_wr", 64'({bus.write_valid, bus.write_data, bus.write_sop, bus.write_eop}), 64'd0);
        chk("rst_op1", 64'({bus1.op_type, bus1.op_addr, bus1.op_num, bus1.op_valid}),
            64'({2'b00, BASE1, 9'd0, 1'b0}));
        rst_n = 1'b1;

        // A: clean loopback, plus a start pulse mid-run that must be ignored
        push_run();
        pulse_start("a_busy");
        repeat (20) @(negedge clk);
        pulse_start("a_busy_mid");
        wait_done("a", 16'd0, 1'b1);

        // B: byte 2 of the first read corrupted
        corrupt_en = 1'b1;
        push_run();
        pulse_start("b_busy");
        wait_done("b", 16'd1, 1'b0);
        corrupt_en = 1'b0;

        // C: slow controller, ready withheld while valid is up
        hold = 5; stall = 3;
        push_run();
        pulse_start("c_busy");
        wait_done("c", 16'd0, 1'b1);
        hold = 2; stall = 0;

        // D: reset in the middle of the write data burst
        push_run();
        pulse_start("d_busy");
        c = 0;
        while (!bus.write_valid && c < 200) begin @(negedge clk); c++; end
        chk("d_in_wrdata", 64'(bus.write_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("d_rst_ctl", 64'({busy, done, pass, err}), 64'd0);
        chk("d_rst_op", 64'({bus.op_type, bus.op_addr, bus.op_num, bus.op_valid}), 64'd0);
        chk("d_rst_wr", 64'({bus.write_valid, bus.write_data, bus.write_sop, bus.write_eop}), 64'd0);
        exp_op_q.delete(); exp_wr_q.delete();
        repeat (3) @(negedge clk);
        chk("d_no_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        push_run();
        pulse_start("d2_busy");
        wait_done("d2", 16'd0, 1'b1);

        // E: P_LEN=1 instance, read returns 3 bytes -> one length error
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("e_busy", 64'(busy1), 64'd1);
        wait_valid1("e_er_op", {OP_ERASE, BASE1, 9'd0});
        @(negedge clk); bus1.op_ready = 1'b0;
        repeat (2) @(negedge clk);
        bus1.op_ready = 1'b1;
        wait_valid1("e_wr_op", {OP_WRITE, BASE1, 9'd1});
        @(negedge clk);
        chk("e_wr_byte", 64'({bus1.write_valid, bus1.write_data, bus1.write_sop, bus1.write_eop}),
            64'({1'b1, pat(SEED1, 0, 0), 2'b11}));
        bus1.op_ready = 1'b0;
        @(negedge clk);
        chk("e_wr_end", 64'(bus1.write_valid), 64'd0);
        @(negedge clk); bus1.op_ready = 1'b1;
        wait_valid1("e_rd_op", {OP_READ, BASE1, 9'd1});
        @(negedge clk); bus1.op_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus1.read_valid = 1'b1;
            bus1.read_data  = pat(SEED1, 0, k);
            bus1.read_sop   = (k == 0);
            bus1.read_eop   = (k == 0);
            @(negedge clk);
        end
        bus1.read_valid = 1'b0; bus1.read_sop = 1'b0; bus1.read_eop = 1'b0;
        @(negedge clk); bus1.op_ready = 1'b1;
        c = 0;
        while (!done1 && c < 50) begin @(negedge clk); c++; end
        chk("e_done", 64'(done1), 64'd1);
        chk("e_err", 64'(err1), 64'd1);
        @(negedge clk);
        chk("e_pass", 64'({pass1, busy1}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
